sprite_motion_sched: RTL and testbench
======================================

SPRITE_MOTION_SCHED -- requirements
Module: sprite_motion_sched

Interface
REQ-001 SHALL have parameter N_SPRITES, default 4, number of sprite slots sequenced per frame.
REQ-002 SHALL have parameter H_VISIBLE, default 640, visible width in pixels.
REQ-003 SHALL have parameter V_VISIBLE, default 480, visible height in pixels.
REQ-004 SHALL have parameter SPRITE_SIDE, default 16, sprite edge length in pixels.
REQ-005 SHALL have port clk, input, 1, system clock; reset rst, synchronous, active-high; clock clk.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port frame_stb, input, 1, one-cycle pulse at start of vertical blanking.
REQ-008 SHALL have port dir_req, input, N_SPRITES*2, per-slot direction (0 up, 1 down, 2 left, 3 right).
REQ-009 SHALL have port move_en, input, N_SPRITES, per-slot move request; 0 means the slot holds position.
REQ-010 SHALL have port speed, input, N_SPRITES*3, per-slot step in pixels per frame (0..7).
REQ-011 SHALL have port clr_overrun, input, 1, clears the overrun flag.
REQ-012 SHALL have port pos_x, output, N_SPRITES*10, per-slot top-left x.
REQ-013 SHALL have port pos_y, output, N_SPRITES*9, per-slot top-left y.
REQ-014 SHALL have port busy, output, 1, high while a frame update is in progress.
REQ-015 SHALL have port upd_done, output, 1, one-cycle pulse when all slots are updated.
REQ-016 SHALL have port overrun, output, 1, sticky flag for a frame_stb that arrives while busy.

Function
REQ-017 SHALL use FSM states IDLE, LOAD, STORE, DONE.
REQ-018 IDLE and frame_stb: snapshot dir_req, move_en and speed; set idx=0; go to LOAD.
REQ-019 LOAD: latch slot idx position into working registers; go to STORE.
REQ-020 STORE: write the computed position to slot idx.
- If idx==N_SPRITES-1, go to DONE; otherwise increment idx and go to LOAD.
REQ-021 DONE: assert upd_done for exactly one cycle, then go to IDLE.
- Latency from frame_stb to upd_done is 2*N_SPRITES+1 cycles (9 at default).
REQ-022 busy SHALL be high in LOAD, STORE and DONE, and low in IDLE.
REQ-023 Step arithmetic SHALL use width+1 signed intermediates so underflow is detected, not wrapped.
REQ-024 Clamp rules:
- x range is [0, H_VISIBLE-SPRITE_SIDE].
- y range is [0, V_VISIBLE-SPRITE_SIDE].
- A result outside its range saturates to the nearer bound.
REQ-025 move_en=0 or speed=0 SHALL leave the slot's position unchanged.
REQ-026 A slot's pos_x/pos_y SHALL change only on the clock edge ending its STORE cycle.
- The other slots' outputs stay stable during that edge.
REQ-027 frame_stb while busy SHALL be ignored and SHALL set overrun.
- If clr_overrun and a new overrun occur in the same cycle, the set wins.
REQ-028 Inputs changing during an update SHALL NOT affect the current frame; only the snapshot is used.

Reset
REQ-029 rst SHALL take priority over frame_stb and clr_overrun in the same cycle.
REQ-030 rst mid-update SHALL abort the update and return the FSM to IDLE with idx=0.
REQ-031 Reset values:
- busy=0, upd_done=0, overrun=0.
- Every slot pos_x=(H_VISIBLE-SPRITE_SIDE)/2 (312 at default).
- Every slot pos_y=(V_VISIBLE-SPRITE_SIDE)/2 (232 at default).

Configuration
REQ-032 With SPRITE_TUNNEL_WRAP_EN defined, horizontal moves SHALL wrap instead of clamp.
- x below 0 becomes H_VISIBLE-SPRITE_SIDE.
- x above H_VISIBLE-SPRITE_SIDE becomes 0.
- y always clamps.
REQ-033 Without SPRITE_TUNNEL_WRAP_EN, x SHALL clamp per REQ-024.

Structure
REQ-034 Shared package pacman_pkg SHALL hold:
- the dir_t enum (UP, DOWN, LEFT, RIGHT);
- the state_t enum;
- default screen and sprite-size constants.
REQ-035 Per-slot next-position arithmetic SHALL be the combinational sub-module sprite_step, instantiated once and time-shared across slots.

Verification
REQ-036 Reset, then one frame_stb with move_en=0 -> busy high for 9 cycles, upd_done at cycle 9, all positions 312/232.
REQ-037 Slot 2 RIGHT speed 5, one frame -> slot 2 x=317, other slots unchanged; slot 2 output changes only at the edge ending its STORE cycle.
REQ-038 Slot 0 at x=2, LEFT speed 7 -> x=0 without the macro; x=624 with SPRITE_TUNNEL_WRAP_EN.
REQ-039 Slot 1 at y=460, DOWN speed 7 -> y=464 clamped (both builds).
REQ-040 Second frame_stb 3 cycles after the first -> ignored, overrun=1, positions reflect one update only; clr_overrun -> overrun=0.
REQ-041 rst asserted in slot 1 STORE cycle -> next cycle busy=0, all positions 312/232, no upd_done pulse.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and constants for the sprite motion scheduler.
// Optional feature macro: SPRITE_TUNNEL_WRAP_EN (horizontal wrap instead of clamp).
package pacman_pkg;

    // Direction encoding as it appears on the dir_req input bus.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default screen geometry and slot count.
    localparam int N_SPRITES_DEF   = 4;
    localparam int H_VISIBLE_DEF   = 640;
    localparam int V_VISIBLE_DEF   = 480;
    localparam int SPRITE_SIDE_DEF = 16;

    // Field widths of the per-slot buses.
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int SPD_W = 3;

endpackage

// File: rtl/sprite_step.sv
// Combinational next-position calculator for one sprite slot.
// Uses one extra signed bit so a step past the left/top edge shows up as a
// negative value instead of wrapping around the field width.
// With SPRITE_TUNNEL_WRAP_EN defined, x wraps to the opposite edge; y always clamps.
module sprite_step
    import pacman_pkg::*;
#(
    parameter int H_VISIBLE   = H_VISIBLE_DEF,
    parameter int V_VISIBLE   = V_VISIBLE_DEF,
    parameter int SPRITE_SIDE = SPRITE_SIDE_DEF
) (
    input  logic [X_W-1:0]   cur_x,
    input  logic [Y_W-1:0]   cur_y,
    input  dir_t             dir,
    input  logic             move_en,
    input  logic [SPD_W-1:0] speed,
    output logic [X_W-1:0]   next_x,
    output logic [Y_W-1:0]   next_y
);

    localparam logic signed [X_W:0] X_HI = (X_W+1)'(H_VISIBLE - SPRITE_SIDE);
    localparam logic signed [Y_W:0] Y_HI = (Y_W+1)'(V_VISIBLE - SPRITE_SIDE);

    logic signed [X_W:0] sx;
    logic signed [Y_W:0] sy;
    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;

    // Apply the step in signed arithmetic, then bring the result back into range.
    always_comb begin
        dx = $signed({{(X_W+1-SPD_W){1'b0}}, speed});
        dy = $signed({{(Y_W+1-SPD_W){1'b0}}, speed});
        sx = $signed({1'b0, cur_x});
        sy = $signed({1'b0, cur_y});
        // A zero speed adds zero, so it needs no special case.
        if (move_en) begin
            case (dir)
                UP:      sy = sy - dy;
                DOWN:    sy = sy + dy;
                LEFT:    sx = sx - dx;
                RIGHT:   sx = sx + dx;
                default: ;
            endcase
        end

`ifdef SPRITE_TUNNEL_WRAP_EN
        if (sx[X_W])        next_x = X_HI[X_W-1:0];
        else if (sx > X_HI) next_x = '0;
        else                next_x = sx[X_W-1:0];
`else
        if (sx[X_W])        next_x = '0;
        else if (sx > X_HI) next_x = X_HI[X_W-1:0];
        else                next_x = sx[X_W-1:0];
`endif

        if (sy[Y_W])        next_y = '0;
        else if (sy > Y_HI) next_y = Y_HI[Y_W-1:0];
        else                next_y = sy[Y_W-1:0];
    end

endmodule

// File: rtl/sprite_motion_sched.sv
// Per-frame sprite position scheduler. On frame_stb it snapshots the move
// requests and walks every slot through LOAD/STORE, sharing one sprite_step.
// Handshake: frame_stb is a single-cycle request accepted only in IDLE; busy
// stays high from acceptance until upd_done has pulsed, and a frame_stb seen
// while busy is dropped and latched into the sticky overrun flag.
// fsm_state exposes the FSM for debug/observation.
// Optional feature macro: SPRITE_TUNNEL_WRAP_EN (see sprite_step).
module sprite_motion_sched
    import pacman_pkg::*;
#(
    parameter int N_SPRITES   = N_SPRITES_DEF,
    parameter int H_VISIBLE   = H_VISIBLE_DEF,
    parameter int V_VISIBLE   = V_VISIBLE_DEF,
    parameter int SPRITE_SIDE = SPRITE_SIDE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_stb,
    input  logic [N_SPRITES*2-1:0]     dir_req,
    input  logic [N_SPRITES-1:0]       move_en,
    input  logic [N_SPRITES*SPD_W-1:0] speed,
    input  logic                       clr_overrun,
    output logic [N_SPRITES*X_W-1:0]   pos_x,
    output logic [N_SPRITES*Y_W-1:0]   pos_y,
    output logic                       busy,
    output logic                       upd_done,
    output logic                       overrun,
    output logic [1:0]                 fsm_state
);

    localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam logic [X_W-1:0]   X_HOME = X_W'((H_VISIBLE - SPRITE_SIDE) / 2);
    localparam logic [Y_W-1:0]   Y_HOME = Y_W'((V_VISIBLE - SPRITE_SIDE) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SPRITES - 1);

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [N_SPRITES*2-1:0]     dir_snap;
    logic [N_SPRITES-1:0]       en_snap;
    logic [N_SPRITES*SPD_W-1:0] spd_snap;
    logic [X_W-1:0]             x_mem [N_SPRITES];
    logic [Y_W-1:0]             y_mem [N_SPRITES];
    logic [X_W-1:0]             cur_x;
    logic [Y_W-1:0]             cur_y;
    dir_t                       cur_dir;
    logic                       cur_en;
    logic [SPD_W-1:0]           cur_spd;
    logic [X_W-1:0]             next_x;
    logic [Y_W-1:0]             next_y;

    // Select the snapshot fields of the slot currently being processed.
    always_comb begin
        cur_dir = dir_t'(dir_snap[idx*2 +: 2]);
        cur_en  = en_snap[idx];
        cur_spd = spd_snap[idx*SPD_W +: SPD_W];
    end

    sprite_step #(
        .H_VISIBLE   (H_VISIBLE),
        .V_VISIBLE   (V_VISIBLE),
        .SPRITE_SIDE (SPRITE_SIDE)
    ) u_step (
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .dir     (cur_dir),
        .move_en (cur_en),
        .speed   (cur_spd),
        .next_x  (next_x),
        .next_y  (next_y)
    );

    // Scheduler FSM, position store and status flags; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            upd_done <= 1'b0;
            overrun  <= 1'b0;
            dir_snap <= '0;
            en_snap  <= '0;
            spd_snap <= '0;
            cur_x    <= X_HOME;
            cur_y    <= Y_HOME;
            for (int s = 0; s < N_SPRITES; s++) begin
                x_mem[s] <= X_HOME;
                y_mem[s] <= Y_HOME;
            end
        end else begin
            upd_done <= 1'b0;
            // A fresh overrun beats a simultaneous clear.
            if (frame_stb && state != IDLE) overrun <= 1'b1;
            else if (clr_overrun)           overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_stb) begin
                        dir_snap <= dir_req;
                        en_snap  <= move_en;
                        spd_snap <= speed;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    cur_x <= x_mem[idx];
                    cur_y <= y_mem[idx];
                    state <= STORE;
                end
                STORE: begin
                    x_mem[idx] <= next_x;
                    y_mem[idx] <= next_y;
                    if (idx == IDX_LAST) begin
                        upd_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fsm_state = state;

    // Flatten the per-slot position store onto the output buses.
    for (genvar g = 0; g < N_SPRITES; g++) begin : g_out
        assign pos_x[g*X_W +: X_W] = x_mem[g];
        assign pos_y[g*Y_W +: Y_W] = y_mem[g];
    end

endmodule

// File: tb/tb_sprite_motion_sched.sv
// Self-checking bench for sprite_motion_sched with a behavioural position model.
module tb_sprite_motion_sched;

    localparam int N      = 4;
    localparam int XW     = 10;
    localparam int YW     = 9;
    localparam int X_MAX  = 624;
    localparam int Y_MAX  = 464;
    localparam int X_HOME = 312;
    localparam int Y_HOME = 232;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_stb;
    logic          clr_overrun;
    logic [7:0]    dir_req;
    logic [3:0]    move_en;
    logic [11:0]   speed;
    logic [39:0]   pos_x;
    logic [35:0]   pos_y;
    logic          busy;
    logic          upd_done;
    logic          overrun;
    logic [1:0]    fsm_state;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int mx [N];
    int my [N];
    int ox [N];
    int oy [N];
    logic exp_ov;

    always #5 clk = ~clk;

    sprite_motion_sched dut (
        .clk         (clk),
        .rst         (rst),
        .frame_stb   (frame_stb),
        .dir_req     (dir_req),
        .move_en     (move_en),
        .speed       (speed),
        .clr_overrun (clr_overrun),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .busy        (busy),
        .upd_done    (upd_done),
        .overrun     (overrun),
        .fsm_state   (fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Screen-level motion rule: move by speed in the requested direction, then clamp/wrap.
    function automatic void model_frame(input logic [7:0] d, input logic [3:0] en, input logic [11:0] sp);
        int v, x, y;
        for (int s = 0; s < N; s++) begin
            v = int'(sp[s*3 +: 3]);
            x = mx[s];
            y = my[s];
            if (en[s]) begin
                case (d[s*2 +: 2])
                    2'd0: y = y - v;
                    2'd1: y = y + v;
                    2'd2: x = x - v;
                    default: x = x + v;
                endcase
            end
`ifdef SPRITE_TUNNEL_WRAP_EN
            if (x < 0) x = X_MAX;
            else if (x > X_MAX) x = 0;
`else
            if (x < 0) x = 0;
            else if (x > X_MAX) x = X_MAX;
`endif
            if (y < 0) y = 0;
            else if (y > Y_MAX) y = Y_MAX;
            mx[s] = x;
            my[s] = y;
        end
    endfunction

    function automatic void model_home();
        for (int s = 0; s < N; s++) begin
            mx[s] = X_HOME; my[s] = Y_HOME;
            ox[s] = X_HOME; oy[s] = Y_HOME;
        end
    endfunction

    // Slot s is written at the edge ending cycle 2s+2, so its new value shows from cycle 2s+3.
    task automatic check_positions(input string tag, input int k);
        bit upd;
        for (int s = 0; s < N; s++) begin
            upd = (k >= 2*s + 3);
            check($sformatf("%s x%0d c%0d", tag, s, k), 32'(pos_x[s*XW +: XW]), upd ? mx[s] : ox[s]);
            check($sformatf("%s y%0d c%0d", tag, s, k), 32'(pos_y[s*YW +: YW]), upd ? my[s] : oy[s]);
        end
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, " busy"}, 32'(busy), 0);
            check({tag, " done"}, 32'(upd_done), 0);
            check({tag, " ovr"}, 32'(overrun), 32'(exp_ov));
            check_positions(tag, 100);
        end
    endtask

    // One frame: pulse frame_stb, scramble inputs after the snapshot, check every cycle.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [3:0] en,
                             input logic [11:0] sp, input int ov_at, input bit ov_clr, input int rst_at);
        for (int s = 0; s < N; s++) begin
            ox[s] = mx[s]; oy[s] = my[s];
        end
        model_frame(d, en, sp);
        @(negedge clk);
        dir_req = d; move_en = en; speed = sp;
        frame_stb = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                frame_stb = 1'b0;
                dir_req   = 8'($urandom);
                move_en   = 4'($urandom);
                speed     = 12'($urandom);
            end
            if (k == ov_at + 1) begin
                frame_stb   = 1'b0;
                clr_overrun = 1'b0;
            end
            check($sformatf("%s busy c%0d", tag, k), 32'(busy), 1);
            check($sformatf("%s done c%0d", tag, k), 32'(upd_done), (k == 9) ? 1 : 0);
            check($sformatf("%s ovr c%0d", tag, k), 32'(overrun), 32'(exp_ov));
            check_positions(tag, k);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                model_home();
                exp_ov = 1'b0;
                check({tag, " rst busy"}, 32'(busy), 0);
                check({tag, " rst done"}, 32'(upd_done), 0);
                check({tag, " rst ovr"}, 32'(overrun), 0);
                check_positions({tag, " rst"}, 100);
                idle_check({tag, " post_rst"}, 12);
                return;
            end
            if (k == ov_at) begin
                frame_stb   = 1'b1;
                clr_overrun = ov_clr;
                exp_ov      = 1'b1;
            end
        end
        @(negedge clk);
        check({tag, " end busy"}, 32'(busy), 0);
        check({tag, " end done"}, 32'(upd_done), 0);
        check_positions({tag, " end"}, 100);
        for (int i = 0; i < 30 && busy; i++) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  d;
        logic [3:0]  en;
        logic [11:0] sp;

        rst = 1'b1; frame_stb = 1'b0; clr_overrun = 1'b0;
        dir_req = '0; move_en = '0; speed = '0;
        exp_ov = 1'b0;
        model_home();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(upd_done), 0);
        check("reset ovr", 32'(overrun), 0);
        check("reset x0", 32'(pos_x[9:0]), 312);
        check("reset y3", 32'(pos_y[35:27]), 232);
        check_positions("reset", 100);

        // Frame with every slot holding.
        run_frame("hold", 8'($urandom), 4'b0000, 12'($urandom), 0, 1'b0, 0);

        // Slot 2 moves right by 5.
        run_frame("s2_right", {2'd0, 2'd3, 2'd0, 2'd0}, 4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, 0, 1'b0, 0);
        check("s2_right x2", 32'(pos_x[29:20]), 317);

        // Enabled but zero speed holds.
        run_frame("zero_spd", 8'($urandom), 4'b1111, 12'd0, 0, 1'b0, 0);

        // Walk slot 0 toward the left edge and slot 1 toward the bottom edge.
        for (int i = 0; i < 44; i++) begin
            d  = {2'd0, 2'd0, 2'd1, 2'd2};
            en = {2'b00, (i < 32), 1'b1};
            sp = {6'd0, 3'd7, 3'd7};
            run_frame($sformatf("walk%0d", i), d, en, sp, 0, 1'b0, 0);
        end
        run_frame("approach", {2'd0, 2'd0, 2'd1, 2'd2}, 4'b0011, {6'd0, 3'd4, 3'd2}, 0, 1'b0, 0);
        check("edge x0=2", 32'(pos_x[9:0]), 2);
        check("edge y1=460", 32'(pos_y[17:9]), 460);
        run_frame("edge", {2'd0, 2'd0, 2'd1, 2'd2}, 4'b0011, {6'd0, 3'd7, 3'd7}, 0, 1'b0, 0);
`ifdef SPRITE_TUNNEL_WRAP_EN
        check("left wrap x0", 32'(pos_x[9:0]), 624);
`else
        check("left clamp x0", 32'(pos_x[9:0]), 0);
`endif
        check("down clamp y1", 32'(pos_y[17:9]), 464);

        // Randomised frames.
        for (int i = 0; i < 40; i++)
            run_frame($sformatf("rand%0d", i), 8'($urandom), 4'($urandom), 12'($urandom), 0, 1'b0, 0);

        // Second frame_stb three cycles in: ignored, overrun sticks.
        run_frame("overrun", 8'($urandom), 4'b1111, 12'($urandom), 3, 1'b0, 0);
        idle_check("ovr_hold", 12);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        exp_ov = 1'b0;
        check("clr ovr", 32'(overrun), 0);

        // Clear and new overrun in the same cycle: set wins.
        run_frame("ovr_set_wins", 8'($urandom), 4'($urandom), 12'($urandom), 5, 1'b1, 0);
        idle_check("ovr_win_hold", 3);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        exp_ov = 1'b0;
        check("clr ovr2", 32'(overrun), 0);

        // Move away from home, then reset during slot 1 STORE.
        run_frame("pre_rst", 8'($urandom), 4'b1111, 12'hfff, 0, 1'b0, 0);
        run_frame("mid_rst", 8'($urandom), 4'b1111, 12'hfff, 0, 1'b0, 4);

        // rst beats frame_stb and clr_overrun in the same cycle.
        run_frame("pre_pri", 8'($urandom), 4'b1111, 12'hfff, 2, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1; frame_stb = 1'b1; clr_overrun = 1'b1;
        @(negedge clk);
        rst = 1'b0; frame_stb = 1'b0; clr_overrun = 1'b0;
        model_home();
        exp_ov = 1'b0;
        check("rst_pri busy", 32'(busy), 0);
        check("rst_pri ovr", 32'(overrun), 0);
        idle_check("rst_pri", 4);

        // Normal operation after reset.
        run_frame("after_rst", 8'($urandom), 4'($urandom), 12'($urandom), 0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
